// File: rtl/pico_seq.sv
`default_nettype none
// ============================================================================
// Module   : pico_seq
// Purpose  : picoMips program sequencer and instruction decoder. It holds the
//            PC, decodes ALU and register-file controls, and runs the
//            button wait-handshake.
// Options  : PICO_SEQ_BTN_SYNC_EN adds a 2-flop synchronizer on Btn.
// Revision : 1.0 - initial release
// ============================================================================
module pico_seq #(
    parameter int PC_W = 8,
    parameter int RA_W = 4
) (
    input  logic            Clock,
    input  logic            nReset,
    input  logic [15:0]     Instr,
    input  logic [7:0]      ACC,
    input  logic            Btn,
    output logic [PC_W-1:0] PC,
    output logic [7:0]      Imm,
    output logic [RA_W-1:0] RegAddr,
    output logic            RegWE,
    output logic            WE,
    output logic            SelImm,
    output logic            SelSW,
    output logic            SelRegData,
    output logic            UseMul,
    output logic            UseACC,
    output logic            Halted
);

    localparam logic [3:0] C_OP_NOP   = 4'h0;
    localparam logic [3:0] C_OP_LDI   = 4'h1;
    localparam logic [3:0] C_OP_LDSW  = 4'h2;
    localparam logic [3:0] C_OP_LDR   = 4'h3;
    localparam logic [3:0] C_OP_ADDI  = 4'h4;
    localparam logic [3:0] C_OP_ADDR  = 4'h5;
    localparam logic [3:0] C_OP_ADDSW = 4'h6;
    localparam logic [3:0] C_OP_MULI  = 4'h7;
    localparam logic [3:0] C_OP_MADR  = 4'h8;
    localparam logic [3:0] C_OP_STR   = 4'h9;
    localparam logic [3:0] C_OP_JMP   = 4'hA;
    localparam logic [3:0] C_OP_BNZ   = 4'hB;
    localparam logic [3:0] C_OP_WAITP = 4'hC;
    localparam logic [3:0] C_OP_BZ    = 4'hD;
    localparam logic [3:0] C_OP_BNEG  = 4'hE;
    localparam logic [3:0] C_OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_WAIT_LO = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_target;
    logic [3:0]        w_opcode;
    logic              w_btn_s;

`ifdef PICO_SEQ_BTN_SYNC_EN
    logic btn_meta_q, btn_sync_q;

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            btn_meta_q <= Btn;
            btn_sync_q <= btn_meta_q;
        end
    end

    assign w_btn_s = btn_sync_q;
`else
    assign w_btn_s = Btn;
`endif

    // Branch target is the 8-bit immediate resized to the PC width.
    generate
        if (PC_W > 8) begin : g_tgt_zext
            assign w_target = {{(PC_W-8){1'b0}}, Instr[7:0]};
        end else if (PC_W == 8) begin : g_tgt_same
            assign w_target = Instr[7:0];
        end else begin : g_tgt_trunc
            assign w_target = Instr[PC_W-1:0];
        end
    endgenerate

    assign w_opcode = Instr[15:12];
    assign w_pc_inc = pc_q + PC_W'(1);
    assign PC       = pc_q;
    assign Imm      = Instr[7:0];
    assign RegAddr  = Instr[RA_W+7:8];
    assign Halted   = (state_q == ST_HALT);

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        WE         = 1'b0;
        RegWE      = 1'b0;
        SelImm     = 1'b0;
        SelSW      = 1'b0;
        SelRegData = 1'b0;
        UseMul     = 1'b0;
        UseACC     = 1'b0;

        case (state_q)
            ST_RUN: begin
                pc_d = w_pc_inc;
                case (w_opcode)
                    C_OP_NOP:   ;
                    C_OP_LDI:   begin WE = 1'b1; SelImm = 1'b1; end
                    C_OP_LDSW:  begin WE = 1'b1; SelSW = 1'b1; end
                    C_OP_LDR:   begin WE = 1'b1; SelRegData = 1'b1; end
                    C_OP_ADDI:  begin WE = 1'b1; UseACC = 1'b1; SelImm = 1'b1; end
                    C_OP_ADDR:  begin WE = 1'b1; UseACC = 1'b1; SelRegData = 1'b1; end
                    C_OP_ADDSW: begin WE = 1'b1; UseACC = 1'b1; SelSW = 1'b1; end
                    C_OP_MULI:  begin WE = 1'b1; UseACC = 1'b1; UseMul = 1'b1; end
                    C_OP_MADR: begin
                        WE         = 1'b1;
                        UseACC     = 1'b1;
                        UseMul     = 1'b1;
                        SelRegData = 1'b1;
                    end
                    C_OP_STR:   RegWE = 1'b1;
                    C_OP_JMP:   pc_d = w_target;
                    C_OP_BNZ:   if (ACC != 8'h00) pc_d = w_target;
                    C_OP_WAITP: begin state_d = ST_WAIT_HI; pc_d = pc_q; end
                    C_OP_BZ:    if (ACC == 8'h00) pc_d = w_target;
                    C_OP_BNEG:  if (ACC[7]) pc_d = w_target;
                    C_OP_HALT:  begin state_d = ST_HALT; pc_d = pc_q; end
                    default:    ;
                endcase
            end
            ST_WAIT_HI: begin
                if (w_btn_s) state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                // Release completes the WAITP; only now does the PC move on.
                if (!w_btn_s) begin
                    state_d = ST_RUN;
                    pc_d    = w_pc_inc;
                end
            end
            ST_HALT: ;
            default: state_d = ST_RUN;
        endcase

        if (!nReset) begin
            WE    = 1'b0;
            RegWE = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pico_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pico_seq
// Purpose  : Directed table-driven bench for pico_seq plus hand-written
//            wait-handshake, halt and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pico_seq;

`ifdef PICO_SEQ_BTN_SYNC_EN
    localparam int C_LAT = 3;
`else
    localparam int C_LAT = 1;
`endif

    logic        Clock;
    logic        nReset;
    logic [15:0] Instr;
    logic [7:0]  ACC;
    logic        Btn;
    logic [7:0]  PC;
    logic [7:0]  Imm;
    logic [3:0]  RegAddr;
    logic        RegWE, WE, SelImm, SelSW, SelRegData, UseMul, UseACC, Halted;
    logic [7:0]  w_ctl;

    int n_vec  = 0;
    int n_miss = 0;

    pico_seq #(.PC_W(8), .RA_W(4)) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .Instr      (Instr),
        .ACC        (ACC),
        .Btn        (Btn),
        .PC         (PC),
        .Imm        (Imm),
        .RegAddr    (RegAddr),
        .RegWE      (RegWE),
        .WE         (WE),
        .SelImm     (SelImm),
        .SelSW      (SelSW),
        .SelRegData (SelRegData),
        .UseMul     (UseMul),
        .UseACC     (UseACC),
        .Halted     (Halted)
    );

    // {WE, RegWE, SelImm, SelSW, SelRegData, UseMul, UseACC, Halted}
    assign w_ctl = {WE, RegWE, SelImm, SelSW, SelRegData, UseMul, UseACC, Halted};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [15:0] instr;
        logic [7:0]  acc;
        logic [7:0]  pc;
        logic        we;
        logic        regwe;
        logic [4:0]  sel;   // SelImm, SelSW, SelRegData, UseMul, UseACC
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{16'h0000, 8'h00, 8'h01, 1'b0, 1'b0, 5'b00000};
        vecs[1]  = '{16'h2011, 8'h00, 8'h02, 1'b1, 1'b0, 5'b01000};
        vecs[2]  = '{16'h3400, 8'h00, 8'h03, 1'b1, 1'b0, 5'b00100};
        vecs[3]  = '{16'h4003, 8'h00, 8'h04, 1'b1, 1'b0, 5'b10001};
        vecs[4]  = '{16'h5100, 8'h00, 8'h05, 1'b1, 1'b0, 5'b00101};
        vecs[5]  = '{16'h6000, 8'h00, 8'h06, 1'b1, 1'b0, 5'b01001};
        vecs[6]  = '{16'h7002, 8'h00, 8'h07, 1'b1, 1'b0, 5'b00011};
        vecs[7]  = '{16'h8207, 8'h00, 8'h08, 1'b1, 1'b0, 5'b00111};
        vecs[8]  = '{16'h9300, 8'h00, 8'h09, 1'b0, 1'b1, 5'b00000};
        vecs[9]  = '{16'hD02A, 8'h00, 8'h0A, 1'b0, 1'b0, 5'b00000};
        vecs[10] = '{16'hD02A, 8'h03, 8'h2A, 1'b0, 1'b0, 5'b00000};
        vecs[11] = '{16'hE010, 8'h80, 8'h2B, 1'b0, 1'b0, 5'b00000};
        vecs[12] = '{16'hE020, 8'h7F, 8'h10, 1'b0, 1'b0, 5'b00000};
        vecs[13] = '{16'hB030, 8'h01, 8'h11, 1'b0, 1'b0, 5'b00000};
        vecs[14] = '{16'hB040, 8'h00, 8'h30, 1'b0, 1'b0, 5'b00000};
        vecs[15] = '{16'hA0FF, 8'h00, 8'h31, 1'b0, 1'b0, 5'b00000};
        vecs[16] = '{16'h0000, 8'h00, 8'hFF, 1'b0, 1'b0, 5'b00000};
        vecs[17] = '{16'hA004, 8'h00, 8'h00, 1'b0, 1'b0, 5'b00000};

        nReset = 1'b0;
        Instr  = 16'h1005;
        ACC    = 8'h00;
        Btn    = 1'b0;

        // Three reset edges with LDI 5 on the bus: enables stay off.
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk("rst_we", 32'({WE, RegWE}), 32'h0);
            chk("rst_pc", 32'(PC), 32'h0);
        end
        nReset = 1'b1;
        #1;
        chk("post_rst_ctl", 32'(w_ctl), 32'hA0);
        chk("post_rst_imm", 32'(Imm), 32'h05);
        chk("post_rst_pc", 32'(PC), 32'h0);
        @(negedge Clock);

        for (int i = 0; i < 18; i++) begin
            Instr = vecs[i].instr;
            ACC   = vecs[i].acc;
            #1;
            chk($sformatf("v%0d_pc", i), 32'(PC), 32'(vecs[i].pc));
            chk($sformatf("v%0d_ctl", i), 32'(w_ctl),
                32'({vecs[i].we, vecs[i].regwe, vecs[i].sel, 1'b0}));
            chk($sformatf("v%0d_imm", i), 32'(Imm), 32'(vecs[i].instr[7:0]));
            chk($sformatf("v%0d_ra", i), 32'(RegAddr), 32'(vecs[i].instr[11:8]));
            @(negedge Clock);
        end

        // WAITP at PC=4: PC holds and enables stay off while waiting.
        Instr = 16'hC000;
        ACC   = 8'h00;
        #1;
        chk("waitp_issue_pc", 32'(PC), 32'h04);
        chk("waitp_issue_ctl", 32'(w_ctl), 32'h00);
        @(negedge Clock);
        Instr = 16'h1005;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("wait_hi_pc", 32'(PC), 32'h04);
            chk("wait_hi_ctl", 32'(w_ctl), 32'h00);
            @(negedge Clock);
        end
        Btn = 1'b1;
        repeat (C_LAT) @(negedge Clock);
        Btn = 1'b0;
        repeat (C_LAT - 1) @(negedge Clock);
        #1;
        chk("wait_lo_pc", 32'(PC), 32'h04);
        chk("wait_lo_ctl", 32'(w_ctl), 32'h00);
        @(negedge Clock);
        #1;
        chk("wait_exit_pc", 32'(PC), 32'h05);
        chk("wait_exit_ctl", 32'(w_ctl), 32'hA0);

        // HALT: sticky, ignores Btn, exited only by reset.
        Instr = 16'hF000;
        #1;
        chk("halt_issue_ctl", 32'(w_ctl), 32'h00);
        @(negedge Clock);
        Instr = 16'h1005;
        for (int i = 0; i < 10; i++) begin
            Btn = ~Btn;
            #1;
            chk("halt_ctl", 32'(w_ctl), 32'h01);
            chk("halt_pc", 32'(PC), 32'h05);
            @(negedge Clock);
        end
        Btn    = 1'b0;
        nReset = 1'b0;
        #1;
        chk("halt_rst_ctl", 32'(w_ctl), 32'h01);
        @(negedge Clock);
        #1;
        chk("halt_rst_pc", 32'(PC), 32'h00);
        chk("halt_rst_ctl2", 32'(w_ctl), 32'h20);

        // Reset while in WAIT_LO returns to RUN at PC=0 without incrementing.
        nReset = 1'b1;
        Instr  = 16'hC000;
        @(negedge Clock);
        Btn = 1'b1;
        repeat (C_LAT) @(negedge Clock);
        #1;
        chk("wlo_pc", 32'(PC), 32'h00);
        nReset = 1'b0;
        Btn    = 1'b0;
        Instr  = 16'h0000;
        @(negedge Clock);
        nReset = 1'b1;
        Instr  = 16'h1005;
        #1;
        chk("wlo_rst_pc", 32'(PC), 32'h00);
        chk("wlo_rst_ctl", 32'(w_ctl), 32'hA0);
        @(negedge Clock);
        #1;
        chk("wlo_run_pc", 32'(PC), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pico_seq.md
Name: pico_seq

Overview:
- Program sequencer and instruction decoder for picoMips. It sits directly upstream of the ALU.
- Holds the program counter and addresses the asynchronous program ROM.
- Decodes each 16-bit instruction into the ALU select/enable controls and the register-file write enable.
- Branches on ACC fed back from the ALU.
- Implements a button wait-handshake state machine used by programs to pace user input.

Parameters:
- PC_W, 8, program counter width; ROM depth 2^PC_W words.
- RA_W, 4, register-file address width; fixed to Instr[11:8], so must be ≤4.

Ports:
- Clock  input  1  system clock, rising edge.
- nReset  input  1  reset, synchronous, active-low.
- Instr  input  16  ROM data at address PC: [15:12] opcode, [11:8] register address, [7:0] immediate.
- ACC  input  8  accumulator from ALU, used for branch conditions.
- Btn  input  1  asynchronous push-button.
- PC  output  PC_W  ROM address.
- Imm  output  8  Instr[7:0] pass-through.
- RegAddr  output  RA_W  Instr[RA_W+7:8].
- RegWE  output  1  register-file write enable; writes ACC to RegAddr.
- WE  output  1  ALU ACC write enable.
- SelImm, SelSW, SelRegData, UseMul, UseACC  output  1 each  ALU operand/operation selects.
- Halted  output  1  high in HALT state.

Behaviour:
- Clock is Clock. nReset is synchronous, active-low.
- Reset:
  - Sets PC=0 and state=RUN, and clears the synchronizer flops.
  - While nReset=0, WE and RegWE are forced 0 combinationally.
  - Halted=0.
  - Reset in any state, including mid-wait or HALT, returns to RUN with PC=0 at the next edge.
- States: RUN, WAIT_HI, WAIT_LO, HALT.
- Decode is combinational from Instr and applies in RUN only.
- In WAIT_HI, WAIT_LO and HALT, all outputs other than PC/Imm/RegAddr/Halted are 0.
- Opcodes. Selects not listed are 0; all complete in one cycle, PC+1, unless noted:
  - 0 NOP: no enables.
  - 1 LDI: WE, SelImm.
  - 2 LDSW: WE, SelSW.
  - 3 LDR: WE, SelRegData.
  - 4 ADDI: WE, UseACC, SelImm.
  - 5 ADDR: WE, UseACC, SelRegData.
  - 6 ADDSW: WE, UseACC, SelSW.
  - 7 MULI: WE, UseACC, UseMul (ACC*Imm).
  - 8 MADR: WE, UseACC, UseMul, SelRegData ((ACC+Reg)*Imm).
  - 9 STR: RegWE.
  - A JMP: PC ← Imm.
  - B BNZ: PC ← Imm if ACC≠0, else PC+1.
  - C WAITP: RUN→WAIT_HI, PC held.
  - D BZ: PC ← Imm if ACC==0, else PC+1.
  - E BNEG: PC ← Imm if ACC[7]=1, else PC+1.
  - F HALT: RUN→HALT, PC held.
- Branch target width:
  - PC_W>8: target is Imm zero-extended.
  - PC_W<8: target is Imm truncated.
- Branch condition samples ACC in the decode cycle. ACC already reflects the preceding instruction's write.
- PC+1 wraps from 2^PC_W−1 to 0.
- Handshake:
  - WAIT_HI: stay until Btn_s=1, then →WAIT_LO.
  - WAIT_LO: stay until Btn_s=0, then →RUN with PC ← PC+1.
  - Btn_s=1 already on WAIT_HI entry moves to WAIT_LO on the next edge.
  - Minimum WAITP duration is 3 cycles including the issue cycle.
- HALT is exited only by reset.
- Exactly one of SelImm/SelSW/SelRegData is asserted at a time, or none.

Optional Feature:
- Macro: PICO_SEQ_BTN_SYNC_EN.
- Defined: Btn passes through a 2-flop synchronizer. Btn_s lags Btn by 2 edges.
- Undefined: Btn_s = Btn directly, no flops.
- Everything else is identical.

Test Plan:
- Reset with Instr=0x1005 (LDI 5), nReset low 3 cycles → PC=0, WE=0 throughout. After release: WE=1, SelImm=1, Imm=0x05, and PC=1 after the next edge.
- ACC=0x00, Instr=0xD02A (BZ 0x2A) → PC=0x2A next edge. ACC=0x03, same Instr → PC=PC+1. ACC=0x80, Instr=0xE010 → PC=0x10.
- Instr=0x9300 (STR r3) → RegWE=1, RegAddr=3, WE=0, PC+1. Instr=0x8207 → WE=UseACC=UseMul=SelRegData=1, RegAddr=2, Imm=0x07.
- WAITP at PC=4, Btn low 6 cycles → PC stays 4, all enables 0.
  - With macro defined: Btn high → WAIT_LO 3 edges later; Btn low → RUN with PC=5 3 edges later.
  - With macro undefined: each transition after 1 edge.
- PC=255 (PC_W=8) with NOP → PC=0 next edge.
- HALT (0xF000) → Halted=1, PC constant and WE=0 for 10 cycles. Btn toggles are ignored. Reset → PC=0, Halted=0.
- Reset asserted while in WAIT_LO → next edge state RUN, PC=0, with no PC increment.
